sc_comp: RTL and testbench
==========================

// Module: sc_comp
// PURPOSE
//  Single-cycle MIPS-32 subset computer: PC, instruction ROM, register file, ALU, data RAM, control.
//  Every instruction completes in one clock. Top-level block under the simulation bench.
//  Reg_Sel/Reg_Data give a debug read port into the register file for board display and checking.
// PARAMETERS
//  IM_DEPTH  128  instruction ROM words, indexed by PC[8:2]
//  DM_DEPTH  128  data RAM words, indexed by addr[8:2]
//  PC_RESET  32'h0000_0000  PC value while and after reset
// PORTS
//  clk       in   1   system clock; all state updates on the rising edge
//  rstn      in   1   reset; asynchronous, active-low
//  Reg_Sel   in   5   debug register index
//  Reg_Data  out  32  RF[Reg_Sel], combinational; 0 when Reg_Sel==0; X allowed when Reg_Sel is X
// BEHAVIOUR
//  Hierarchy fixed for bench access:
//   - top-level nets PC[31:0] and instr[31:0]
//   - instance U_IM of module im holds reg [31:0] ROM[0:IM_DEPTH-1], loaded by $readmemh
//   - instr = ROM[PC[8:2]], combinational
//  Reset (rstn low, async): PC=PC_RESET; all 32 GPRs=0. DM contents not reset.
//  Each rising clk with rstn high: PC<=next PC; at most one GPR write; at most one DM word write.
//  Register file:
//   - 2 comb read ports plus the debug port
//   - write at posedge; writes to $0 dropped; $0 always reads 0
//  Next PC (default PC+4):
//   - beq/bne taken: PC+4+(sext(imm16)<<2)
//   - j/jal: {PCp4[31:28],target26,2'b00}
//   - jr/jalr: rs
//  Supported instructions:
//   - R arithmetic/logic: add addu sub subu and or xor nor slt sltu
//   - R shifts: sll srl sra (shamt), sllv srlv srav (rs[4:0])
//   - R jumps: jr, jalr (rd<=PC+4)
//   - I: addi addiu slti sltiu (sext imm); andi ori xori (zext imm); lui (imm<<16)
//   - memory: lw, sw (addr=rs+sext(imm))
//   - branches: beq, bne; jumps: j, jal ($31<=PC+4)
//  Arithmetic: 32-bit wrap; add/addi/sub overflow ignored (no trap, result written).
//   slt/slti signed compare, sltu/sltiu unsigned; result 1/0 zero-extended.
//  Memory: lw rt<=DM[addr[8:2]], comb read. sw writes DM at posedge. addr[1:0] ignored; addresses wrap mod DM_DEPTH.
//  Undefined opcode/funct: NOP (no GPR/DM write, PC+4). ROM address wraps mod IM_DEPTH.
//  Reset mid-run: PC and GPRs clear immediately; execution restarts at PC_RESET after rstn rises.
// STRUCTURE
//  Package sc_pkg:
//   - opcode/funct localparams
//   - ALU op enum (ADD SUB AND OR XOR NOR SLT SLTU SLL SRL SRA LUI)
//   - control-signal struct (RegWrite RegDst MemWrite MemToReg ALUSrc ExtOp Branch Jump Link JReg)
//  Sub-module: im (instance U_IM) only. RF, ALU, DM, control and PC logic stay inline.
// TESTING
//  1 Reset: pulse rstn low 5-25ns, no clk edge -> PC=0, instr=ROM[0], Reg_Sel=7 gives 0.
//  2 ROM[0]=20070005 (addi $7,$0,5); 1 edge -> Reg_Sel=7 gives 5, PC=4.
//  3 ori $1,$0,0x1234; sw $1,4($0); lw $7,4($0) -> Reg_Data(7)=0x00001234 after 3 edges.
//  4 beq $0,$0,1 at PC 0 -> next PC=8; bne $0,$0,1 -> next PC=4.
//  5 jal 0x0C000010 at PC 0 -> PC=0x40, Reg_Sel=31 gives 4. jr $31 -> PC=4.
//  6 addi $0,$0,9 -> Reg_Sel=0 gives 0. Assert rstn mid-program -> PC=0 and $7=0 at once.
//  7 Extended: lui $1,0x8000; sra $2,$1,4 -> 0xF8000000; sltu $3,$0,$1 -> 1; slt $4,$1,$0 -> 1.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle MIPS-32 subset computer:
// opcode/funct encodings, ALU operation enum and decoded control word.
package sc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic reg_dst;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic ext_op;
        logic branch;
        logic jump;
        logic link;
        logic jreg;
    } ctrl_t;

endpackage

// File: rtl/sc_comp_if.sv
// Instruction-fetch bus between the core datapath and the instruction ROM.
interface sc_comp_if;
    logic [31:0] addr;
    logic [31:0] instr;

    modport master (output addr, input instr);
    modport slave  (input addr, output instr);
endinterface

// File: rtl/sc_comp_im.sv
// Instruction ROM: word-addressed, combinational read, wraps modulo IM_DEPTH.
module im #(
  parameter int IM_DEPTH = 128
) (
  sc_comp_if.slave bus
);
  localparam int AW = $clog2(IM_DEPTH);

  reg [31:0] ROM [0:IM_DEPTH-1];

  assign bus.instr = ROM[bus.addr[AW+1:2]];

  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
endmodule

// File: rtl/sc_comp.sv
// Single-cycle MIPS-32 subset computer: PC, register file, ALU, data RAM and
// control inline; the instruction ROM is the U_IM sub-module.
module sc_comp
    import sc_pkg::*;
#(
    parameter int          IM_DEPTH = 128,
    parameter int          DM_DEPTH = 128,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  Reg_Sel,
    output logic [31:0] Reg_Data
);
    localparam int DAW = $clog2(DM_DEPTH);

    logic [31:0] PC;
    logic [31:0] instr;

    sc_comp_if im_bus ();
    assign im_bus.addr = PC;
    assign instr       = im_bus.instr;

    im #(.IM_DEPTH(IM_DEPTH)) U_IM (.bus(im_bus.slave));

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign target = instr[25:0];

    logic [31:0] rf [32];
    logic [31:0] dm [DM_DEPTH];
    logic [31:0] rs_data, rt_data;

    assign rs_data  = rf[rs];
    assign rt_data  = rf[rt];
    assign Reg_Data = (Reg_Sel == 5'd0) ? 32'd0 : rf[Reg_Sel];

    ctrl_t   ctrl;
    alu_op_e alu_op;
    logic    sh_var;

    always_comb begin
        ctrl   = '0;
        alu_op = ALU_ADD;
        sh_var = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; sh_var = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; sh_var = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; sh_var = 1'b1; end
                    FN_JR:   begin ctrl.reg_write = 1'b0; ctrl.jreg = 1'b1; end
                    FN_JALR: begin ctrl.jreg = 1'b1; ctrl.link = 1'b1; end
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1;
            end
            OP_SLTI: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1; alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1; alu_op = ALU_SLTU;
            end
            OP_ANDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_OR;  end
            OP_XORI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_XOR; end
            OP_LUI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_LUI; end
            OP_LW: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1; ctrl.mem_to_reg = 1'b1;
            end
            OP_SW:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.ext_op = 1'b1; end
            OP_BEQ, OP_BNE: ctrl.branch = 1'b1;
            OP_J:   ctrl.jump = 1'b1;
            OP_JAL: begin ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_write = 1'b1; end
            default: ;
        endcase
    end

    logic [31:0]        imm_ext, alu_b, alu_y;
    logic signed [31:0] a_s, b_s;
    logic [4:0]         sh;

    assign imm_ext = ctrl.ext_op ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
    assign alu_b   = ctrl.alu_src ? imm_ext : rt_data;
    assign a_s     = rs_data;
    assign b_s     = alu_b;
    assign sh      = sh_var ? rs_data[4:0] : shamt;

    // Arithmetic wraps silently; overflow never traps.
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_y = rs_data + alu_b;
            ALU_SUB:  alu_y = rs_data - alu_b;
            ALU_AND:  alu_y = rs_data & alu_b;
            ALU_OR:   alu_y = rs_data | alu_b;
            ALU_XOR:  alu_y = rs_data ^ alu_b;
            ALU_NOR:  alu_y = ~(rs_data | alu_b);
            ALU_SLT:  alu_y = {31'd0, a_s < b_s};
            ALU_SLTU: alu_y = {31'd0, rs_data < alu_b};
            ALU_SLL:  alu_y = alu_b << sh;
            ALU_SRL:  alu_y = alu_b >> sh;
            ALU_SRA:  alu_y = b_s >>> sh;
            ALU_LUI:  alu_y = {imm16, 16'h0000};
            default:  alu_y = 32'd0;
        endcase
    end

    logic [DAW-1:0] dm_idx;
    logic [31:0]    dm_rdata;

    assign dm_idx   = alu_y[DAW+1:2];
    assign dm_rdata = dm[dm_idx];

    always_ff @(posedge clk) begin
        if (rstn && ctrl.mem_write) dm[dm_idx] <= rt_data;
    end

    logic [31:0] pc_p4, br_tgt, next_pc, wd;
    logic [4:0]  wa;
    logic        br_taken;

    assign pc_p4    = PC + 32'd4;
    assign br_tgt   = pc_p4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign br_taken = ctrl.branch && ((op == OP_BNE) ? (rs_data != rt_data) : (rs_data == rt_data));
    assign next_pc  = ctrl.jreg ? rs_data :
                      ctrl.jump ? {pc_p4[31:28], target, 2'b00} :
                      br_taken  ? br_tgt : pc_p4;

    // jal links into $31; jalr links into rd like any other R-type result.
    assign wa = ctrl.reg_dst ? rd : (ctrl.link ? 5'd31 : rt);
    assign wd = ctrl.link ? pc_p4 : (ctrl.mem_to_reg ? dm_rdata : alu_y);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            PC <= PC_RESET;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            PC <= next_pc;
            if (ctrl.reg_write && (wa != 5'd0)) rf[wa] <= wd;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{alu_y[31:DAW+2], alu_y[1:0]};
endmodule

// File: tb/tb_sc_comp.sv
// Bench for sc_comp: instruction-level reference model checked every cycle,
// plus hand-computed expectations for selected registers and PC values.
module tb_sc_comp;

    logic        clk;
    logic        rstn;
    logic [4:0]  Reg_Sel;
    logic [31:0] Reg_Data;

    sc_comp dut (
        .clk      (clk),
        .rstn     (rstn),
        .Reg_Sel  (Reg_Sel),
        .Reg_Data (Reg_Data)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_rf  [32];
    logic [31:0] m_dm  [128];
    logic [31:0] m_rom [128];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic lit_reg(input string nm, input logic [4:0] sel, input logic [31:0] exp);
        Reg_Sel = sel;
        #1;
        chk(nm, Reg_Data, exp);
    endtask

    task automatic set_rom(input int idx, input logic [31:0] w);
        dut.U_IM.ROM[idx] = w;
        m_rom[idx] = w;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) set_rom(i, 32'h0);
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // Architectural effect of one instruction on the model state.
    task automatic model_step();
        logic [31:0] ins, rs_v, rt_v, pc4, npc, se, ze, ea;
        logic [4:0]  rs, rt, rd, sh;
        ins  = m_rom[m_pc[8:2]];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        rs_v = m_rf[rs];
        rt_v = m_rf[rt];
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'h0, ins[15:0]};
        ea   = rs_v + se;
        pc4  = m_pc + 32'd4;
        npc  = pc4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h00: wr(rd, rt_v << sh);
                6'h02: wr(rd, rt_v >> sh);
                6'h03: wr(rd, $signed(rt_v) >>> sh);
                6'h04: wr(rd, rt_v << rs_v[4:0]);
                6'h06: wr(rd, rt_v >> rs_v[4:0]);
                6'h07: wr(rd, $signed(rt_v) >>> rs_v[4:0]);
                6'h08: npc = rs_v;
                6'h09: begin npc = rs_v; wr(rd, pc4); end
                6'h20, 6'h21: wr(rd, rs_v + rt_v);
                6'h22, 6'h23: wr(rd, rs_v - rt_v);
                6'h24: wr(rd, rs_v & rt_v);
                6'h25: wr(rd, rs_v | rt_v);
                6'h26: wr(rd, rs_v ^ rt_v);
                6'h27: wr(rd, ~(rs_v | rt_v));
                6'h2A: wr(rd, ($signed(rs_v) < $signed(rt_v)) ? 32'd1 : 32'd0);
                6'h2B: wr(rd, (rs_v < rt_v) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; wr(5'd31, pc4); end
            6'h04: if (rs_v == rt_v) npc = pc4 + (se << 2);
            6'h05: if (rs_v != rt_v) npc = pc4 + (se << 2);
            6'h08, 6'h09: wr(rt, rs_v + se);
            6'h0A: wr(rt, ($signed(rs_v) < $signed(se)) ? 32'd1 : 32'd0);
            6'h0B: wr(rt, (rs_v < se) ? 32'd1 : 32'd0);
            6'h0C: wr(rt, rs_v & ze);
            6'h0D: wr(rt, rs_v | ze);
            6'h0E: wr(rt, rs_v ^ ze);
            6'h0F: wr(rt, {ins[15:0], 16'h0});
            6'h23: wr(rt, m_dm[ea[8:2]]);
            6'h2B: m_dm[ea[8:2]] = rt_v;
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic compare();
        chk("pc", dut.PC, m_pc);
        chk("instr", dut.instr, m_rom[m_pc[8:2]]);
        for (int r = 0; r < 32; r++) begin
            Reg_Sel = 5'(r);
            #1;
            chk($sformatf("rf%0d", r), Reg_Data, m_rf[r]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rstn) model_step();
        #1;
        compare();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rstn    = 1'b1;
        Reg_Sel = 5'd0;
        for (int i = 0; i < 128; i++) m_dm[i] = 32'h0;

        clear_rom();
        set_rom(0,  32'h20070005);  // addi  $7,$0,5
        set_rom(1,  32'h34011234);  // ori   $1,$0,0x1234
        set_rom(2,  32'hAC010004);  // sw    $1,4($0)
        set_rom(3,  32'h8C070004);  // lw    $7,4($0)
        set_rom(4,  32'h3C018000);  // lui   $1,0x8000
        set_rom(5,  32'h00011103);  // sra   $2,$1,4
        set_rom(6,  32'h0001182B);  // sltu  $3,$0,$1
        set_rom(7,  32'h0020202A);  // slt   $4,$1,$0
        set_rom(8,  32'h20000009);  // addi  $0,$0,9
        set_rom(9,  32'h00E12822);  // sub   $5,$7,$1
        set_rom(10, 32'h00613006);  // srlv  $6,$1,$3
        set_rom(11, 32'h00004027);  // nor   $8,$0,$0
        set_rom(12, 32'h29090000);  // slti  $9,$8,0
        set_rom(13, 32'h2C0AFFFF);  // sltiu $10,$0,-1
        set_rom(14, 32'h310BFFFF);  // andi  $11,$8,0xFFFF
        set_rom(15, 32'h396C00FF);  // xori  $12,$11,0xFF
        set_rom(16, 32'h00216820);  // add   $13,$1,$1
        set_rom(17, 32'hFC000000);  // undefined opcode

        #5 rstn = 1'b0;
        model_reset();
        #20 rstn = 1'b1;
        #1;
        chk("reset_pc", dut.PC, 32'h0);
        chk("reset_instr", dut.instr, 32'h20070005);
        lit_reg("reset_r7", 5'd7, 32'h0);

        cycle();
        chk("addi_pc", dut.PC, 32'h4);
        lit_reg("addi_r7", 5'd7, 32'h5);

        cycles(3);
        lit_reg("lw_r7", 5'd7, 32'h00001234);

        cycles(4);
        lit_reg("sra_r2", 5'd2, 32'hF8000000);
        lit_reg("sltu_r3", 5'd3, 32'h1);
        lit_reg("slt_r4", 5'd4, 32'h1);

        cycle();
        lit_reg("r0_stays", 5'd0, 32'h0);

        cycles(9);
        chk("undef_pc", dut.PC, 32'd72);
        lit_reg("sub_r5", 5'd5, 32'h80001234);
        lit_reg("srlv_r6", 5'd6, 32'h40000000);
        lit_reg("nor_r8", 5'd8, 32'hFFFFFFFF);
        lit_reg("slti_r9", 5'd9, 32'h1);
        lit_reg("sltiu_r10", 5'd10, 32'h1);
        lit_reg("andi_r11", 5'd11, 32'h0000FFFF);
        lit_reg("xori_r12", 5'd12, 32'h0000FF00);
        lit_reg("add_ovf_r13", 5'd13, 32'h0);

        rstn = 1'b0;
        #1;
        model_reset();
        chk("midrst_pc", dut.PC, 32'h0);
        lit_reg("midrst_r7", 5'd7, 32'h0);
        lit_reg("midrst_r13", 5'd13, 32'h0);
        rstn = 1'b1;
        cycles(2);
        chk("restart_pc", dut.PC, 32'h8);
        lit_reg("restart_r7", 5'd7, 32'h5);

        rstn = 1'b0;
        clear_rom();
        set_rom(0,  32'h10000001);  // beq  $0,$0,1
        set_rom(1,  32'h20070005);  // addi $7,$0,5 (skipped)
        set_rom(2,  32'h0C000010);  // jal  0x40
        set_rom(3,  32'h14000001);  // bne  $0,$0,1
        set_rom(4,  32'h20060030);  // addi $6,$0,0x30
        set_rom(5,  32'h00C02809);  // jalr $5,$6
        set_rom(12, 32'h1000FFFF);  // beq  $0,$0,-1
        set_rom(16, 32'h03E00008);  // jr   $31
        model_reset();
        #1 rstn = 1'b1;

        cycle();
        chk("beq_pc", dut.PC, 32'h8);
        cycle();
        chk("jal_pc", dut.PC, 32'h40);
        lit_reg("jal_r31", 5'd31, 32'd12);
        cycle();
        chk("jr_pc", dut.PC, 32'd12);
        cycle();
        chk("bne_pc", dut.PC, 32'd16);
        cycles(2);
        chk("jalr_pc", dut.PC, 32'h30);
        lit_reg("jalr_r5", 5'd5, 32'd24);
        cycles(2);
        chk("backbr_pc", dut.PC, 32'h30);
        lit_reg("skip_r7", 5'd7, 32'h0);

        rstn = 1'b0;
        clear_rom();
        set_rom(0, 32'h14000001);   // bne $0,$0,1
        set_rom(1, 32'h0C000010);   // jal 0x40
        model_reset();
        #1 rstn = 1'b1;
        cycle();
        chk("bne_nt_pc", dut.PC, 32'h4);
        cycle();
        chk("jal2_pc", dut.PC, 32'h40);
        lit_reg("jal2_r31", 5'd31, 32'h8);
        cycle();
        chk("nop_pc", dut.PC, 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
